bfs_maze_top: RTL and testbench

//  Breadth-first-search shortest-path solver for a 10x10 grid maze. Cell idx = r*10+c; start (9,0)=90, goal (0,9)=9.
//  On start, latches the maze, floods it with a BFS queue, backtracks from goal, and emits the move list start->goal.

---
 rtl/bfs_pkg.sv | 61 ++++++
 rtl/bfs_maze_if.sv | 36 +++
 rtl/bfs_queue.sv | 66 ++++++
 rtl/bfs_maze_top.sv | 225 ++++++++++++++++++++++
 tb/tb_bfs_maze_top.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bfs_pkg.sv
// Shared types and constants for the 10x10 BFS maze solver.
// Cell index is r*COLS+c. The solver searches from START_IDX, the bottom-left cell,
// to GOAL_IDX, the top-right cell.
// No ports (package).
package bfs_pkg;

    localparam int unsigned ROWS   = 10;
    localparam int unsigned COLS   = 10;
    localparam int unsigned NCELLS = ROWS * COLS;
    localparam int unsigned NMOVES = NCELLS - 1;

    typedef logic [6:0] idx_t;

    localparam idx_t START_IDX = 7'd90;
    localparam idx_t GOAL_IDX  = 7'd9;

    // One-hot move encoding as presented on the path output
    typedef enum logic [3:0] {
        DirUp    = 4'b0001,
        DirDown  = 4'b0010,
        DirLeft  = 4'b0100,
        DirRight = 4'b1000
    } dir_t;

    // Compact move code stored per cell: the move taken from parent into the cell
    typedef enum logic [1:0] {
        MvUp    = 2'd0,
        MvDown  = 2'd1,
        MvLeft  = 2'd2,
        MvRight = 2'd3
    } move_t;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StExpand,
        StBacktrack,
        StDone,
        StFail
    } state_t;

    function automatic dir_t move_onehot(input move_t m);
        dir_t d;
        unique case (m)
            MvUp:    d = DirUp;
            MvDown:  d = DirDown;
            MvLeft:  d = DirLeft;
            default: d = DirRight;
        endcase
        return d;
    endfunction

    function automatic idx_t idx_row(input idx_t i);
        return i / 7'(COLS);
    endfunction

    function automatic idx_t idx_col(input idx_t i);
        return i % 7'(COLS);
    endfunction

endpackage

// File: rtl/bfs_maze_if.sv
// Solver request/result bundle.
// The master side (requester) drives start and maze. The slave side (solver) drives
// path, path_length, path_ready and no_path.
// Optional macro BFS_PERF_CNT_EN adds solve_cycles, a cycle count of the last solve.
interface bfs_maze_if;
    import bfs_pkg::*;

    logic                         start;
    logic [NCELLS-1:0]            maze;        // bit i = cell i, 1 = wall
    logic [NMOVES-1:0][3:0]       path;        // path[i] = one-hot move i
    logic [6:0]                   path_length;
    logic                         path_ready;
    logic                         no_path;
`ifdef BFS_PERF_CNT_EN
    logic [19:0]                  solve_cycles;

    modport master (
        output start, maze,
        input  path, path_length, path_ready, no_path, solve_cycles
    );
    modport slave (
        input  start, maze,
        output path, path_length, path_ready, no_path, solve_cycles
    );
`else
    modport master (
        output start, maze,
        input  path, path_length, path_ready, no_path
    );
    modport slave (
        input  start, maze,
        output path, path_length, path_ready, no_path
    );
`endif

endinterface

// File: rtl/bfs_queue.sv
// BFS work queue: a 100 x 7-bit FIFO with up to four pushes per cycle.
// Ports:
//   clk, rst (async, active-low)
//   clear     - empties the queue; pushes in the same cycle land from slot 0
//   push[3:0] - per-lane push enables; enabled lanes are packed in lane order
//   push_data - per-lane cell index
//   pop       - drop head (ignored when empty)
//   head      - cell at the front of the queue
//   empty     - queue holds no cells
// Every cell is enqueued at most once per solve, so the pointers never pass
// NCELLS between clears and no wrap-around is needed.
module bfs_queue
    import bfs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [3:0] push,
    input  idx_t       push_data [4],
    input  logic       pop,
    output idx_t       head,
    output logic       empty
);

    idx_t mem [NCELLS];
    idx_t rd_ptr_q;
    idx_t wr_ptr_q, wr_ptr_d;
    idx_t slot [4];

    // Pack enabled lanes into consecutive slots
    always_comb begin
        wr_ptr_d = clear ? '0 : wr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            slot[i] = wr_ptr_d;
            if (push[i]) begin
                wr_ptr_d = wr_ptr_d + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            if (clear) begin
                rd_ptr_q <= '0;
            end else if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i] && slot[i] < 7'(NCELLS)) begin
                mem[slot[i]] <= push_data[i];
            end
        end
    end

    assign empty = (rd_ptr_q == wr_ptr_q);
    assign head  = mem[rd_ptr_q];

endmodule

// File: rtl/bfs_maze_top.sv
// Breadth-first shortest-path solver for a 10x10 maze, from cell 90 to cell 9.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - bfs_maze_if.slave: start/maze in; path, path_length, path_ready, no_path out
// Flow: start latches the maze. INIT seeds the queue. EXPAND pops one cell per cycle
// and pushes all of its fresh neighbours. BACKTRACK then walks parent moves from the
// goal, filling path from the last move backwards.
// Optional macro BFS_PERF_CNT_EN adds bus.solve_cycles, the number of busy cycles
// in the last solve.
module bfs_maze_top
    import bfs_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    bfs_maze_if.slave bus
);

    state_t                 state_q, state_d;
    logic [NCELLS-1:0]      maze_q, maze_d;
    logic [NCELLS-1:0]      visited_q, visited_d;
    move_t                  parent_q [NCELLS];
    move_t                  parent_d [NCELLS];
    idx_t                   dist_q [NCELLS];
    idx_t                   dist_d [NCELLS];
    idx_t                   cur_q, cur_d;
    idx_t                   k_q, k_d;
    logic [NMOVES-1:0][3:0] path_q, path_d;
    logic [6:0]             path_length_q, path_length_d;
    logic                   path_ready_q, path_ready_d;
    logic                   no_path_q, no_path_d;

    logic       q_clear, q_pop, q_empty;
    logic [3:0] q_push;
    idx_t       q_push_data [4];
    idx_t       q_head;

    idx_t       head_row, head_col;
    logic [3:0] nb_ok, nb_new;
    idx_t       nb_idx [4];
    logic       goal_hit;
    idx_t       prev_idx;

    bfs_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (q_clear),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head      (q_head),
        .empty     (q_empty)
    );

    // Neighbours of the queue head in UP, DOWN, LEFT, RIGHT order. Off-grid
    // neighbours alias the head itself so the index stays in range.
    always_comb begin
        head_row = idx_row(q_head);
        head_col = idx_col(q_head);
        nb_ok[0] = (head_row != 7'd0);
        nb_ok[1] = (head_row != 7'(ROWS - 1));
        nb_ok[2] = (head_col != 7'd0);
        nb_ok[3] = (head_col != 7'(COLS - 1));
        nb_idx[0] = nb_ok[0] ? q_head - 7'(COLS) : q_head;
        nb_idx[1] = nb_ok[1] ? q_head + 7'(COLS) : q_head;
        nb_idx[2] = nb_ok[2] ? q_head - 7'd1 : q_head;
        nb_idx[3] = nb_ok[3] ? q_head + 7'd1 : q_head;
        goal_hit = 1'b0;
        for (int d = 0; d < 4; d++) begin
            nb_new[d] = nb_ok[d] && !maze_q[nb_idx[d]] && !visited_q[nb_idx[d]];
            if (nb_new[d] && nb_idx[d] == GOAL_IDX) begin
                goal_hit = 1'b1;
            end
        end
    end

    // Undo the move recorded for the backtrack cursor
    always_comb begin
        unique case (parent_q[cur_q])
            MvUp:    prev_idx = cur_q + 7'(COLS);
            MvDown:  prev_idx = cur_q - 7'(COLS);
            MvLeft:  prev_idx = cur_q + 7'd1;
            default: prev_idx = cur_q - 7'd1;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        maze_d        = maze_q;
        visited_d     = visited_q;
        parent_d      = parent_q;
        dist_d        = dist_q;
        cur_d         = cur_q;
        k_d           = k_q;
        path_d        = path_q;
        path_length_d = path_length_q;
        path_ready_d  = path_ready_q;
        no_path_d     = no_path_q;
        q_clear       = 1'b0;
        q_pop         = 1'b0;
        q_push        = '0;
        q_push_data   = nb_idx;

        unique case (state_q)
            StIdle, StDone, StFail: begin
                if (bus.start) begin
                    state_d       = StInit;
                    maze_d        = bus.maze;
                    path_d        = '0;
                    path_length_d = '0;
                    path_ready_d  = 1'b0;
                    no_path_d     = 1'b0;
                end
            end
            StInit: begin
                q_clear   = 1'b1;
                visited_d = '0;
                for (int i = 0; i < NCELLS; i++) begin
                    parent_d[i] = MvUp;
                    dist_d[i]   = '0;
                end
                if (maze_q[START_IDX] || maze_q[GOAL_IDX]) begin
                    state_d   = StFail;
                    no_path_d = 1'b1;
                end else begin
                    visited_d[START_IDX] = 1'b1;
                    q_push[0]            = 1'b1;
                    q_push_data[0]       = START_IDX;
                    state_d              = StExpand;
                end
            end
            StExpand: begin
                if (q_empty) begin
                    state_d   = StFail;
                    no_path_d = 1'b1;
                end else begin
                    q_pop = 1'b1;
                    for (int d = 0; d < 4; d++) begin
                        if (nb_new[d]) begin
                            visited_d[nb_idx[d]] = 1'b1;
                            parent_d[nb_idx[d]]  = move_t'(d[1:0]);
                            dist_d[nb_idx[d]]    = dist_q[q_head] + 7'd1;
                            q_push[d]            = 1'b1;
                        end
                    end
                    // Goal's distance is head distance + 1; last move lands at head distance
                    if (goal_hit) begin
                        state_d       = StBacktrack;
                        cur_d         = GOAL_IDX;
                        k_d           = dist_q[q_head];
                        path_length_d = dist_q[q_head] + 7'd1;
                    end
                end
            end
            StBacktrack: begin
                if (cur_q == START_IDX) begin
                    state_d      = StDone;
                    path_ready_d = 1'b1;
                end else begin
                    path_d[k_q] = move_onehot(parent_q[cur_q]);
                    cur_d       = prev_idx;
                    k_d         = k_q - 7'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            maze_q        <= '0;
            visited_q     <= '0;
            cur_q         <= '0;
            k_q           <= '0;
            path_q        <= '0;
            path_length_q <= '0;
            path_ready_q  <= 1'b0;
            no_path_q     <= 1'b0;
            for (int i = 0; i < NCELLS; i++) begin
                parent_q[i] <= MvUp;
                dist_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            maze_q        <= maze_d;
            visited_q     <= visited_d;
            parent_q      <= parent_d;
            dist_q        <= dist_d;
            cur_q         <= cur_d;
            k_q           <= k_d;
            path_q        <= path_d;
            path_length_q <= path_length_d;
            path_ready_q  <= path_ready_d;
            no_path_q     <= no_path_d;
        end
    end

    assign bus.path        = path_q;
    assign bus.path_length = path_length_q;
    assign bus.path_ready  = path_ready_q;
    assign bus.no_path     = no_path_q;

`ifdef BFS_PERF_CNT_EN
    logic [19:0] solve_cycles_q;
    logic        accept, busy;

    assign accept = bus.start &&
                    (state_q == StIdle || state_q == StDone || state_q == StFail);
    assign busy   = (state_q == StInit || state_q == StExpand || state_q == StBacktrack);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            solve_cycles_q <= '0;
        end else if (accept) begin
            solve_cycles_q <= '0;
        end else if (busy) begin
            solve_cycles_q <= solve_cycles_q + 20'd1;
        end
    end

    assign bus.solve_cycles = solve_cycles_q;
`endif

endmodule

// File: tb/tb_bfs_maze_top.sv
// Self-checking bench for bfs_maze_top. It runs directed mazes and random mazes
// against a queue-based BFS reference model.
module tb_bfs_maze_top;
    import bfs_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bfs_maze_if bus ();

    bfs_maze_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [NCELLS-1:0]      maze1, maze3, mz;
    logic [NMOVES-1:0][3:0] exp1;

    task automatic check(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_row(inout logic [NCELLS-1:0] m, input int r, input string s);
        for (int c = 0; c < 10; c++) begin
            if (s[c] == "#") m[r*10+c] = 1'b1;
        end
    endtask

    // Plain BFS over the grid. Neighbours are taken in UP, DOWN, LEFT, RIGHT order and
    // the first discoverer becomes the parent. The path is rebuilt by walking parents
    // back from the goal.
    task automatic ref_solve(input logic [NCELLS-1:0] m, output bit found, output int len,
                             output logic [NMOVES-1:0][3:0] p);
        int par [100];
        int mv  [100];
        bit vis [100];
        int q [$];
        int trail [$];
        int dr [4] = '{-1, 1, 0, 0};
        int dc [4] = '{0, 0, -1, 1};
        found = 0;
        len   = 0;
        p     = '0;
        if (m[90] || m[9]) return;
        vis[90] = 1;
        q.push_back(90);
        while (q.size() > 0) begin
            int cur;
            int r;
            int c;
            cur = q.pop_front();
            r   = cur / 10;
            c   = cur % 10;
            for (int d = 0; d < 4; d++) begin
                int nr;
                int nc;
                int n;
                nr = r + dr[d];
                nc = c + dc[d];
                if (nr >= 0 && nr < 10 && nc >= 0 && nc < 10) begin
                    n = nr * 10 + nc;
                    if (!m[n] && !vis[n]) begin
                        vis[n] = 1;
                        par[n] = cur;
                        mv[n]  = d;
                        q.push_back(n);
                    end
                end
            end
        end
        if (!vis[9]) return;
        found = 1;
        for (int n = 9; n != 90; n = par[n]) trail.push_front(mv[n]);
        len = trail.size();
        for (int i = 0; i < len; i++) p[i] = 4'(1 << trail[i]);
    endtask

    task automatic pulse_start(input logic [NCELLS-1:0] m);
        logic [127:0] junk;
        @(negedge clk);
        bus.maze  = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        // Scramble the maze input: the latched copy must be used
        junk     = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.maze = junk[99:0];
    endtask

    // Called at the negedge after the start edge; counts edges from the start edge
    task automatic wait_flag(output int cycles, output bit timed_out);
        cycles    = 1;
        timed_out = 0;
        while (!(bus.path_ready || bus.no_path)) begin
            if (cycles >= 2000) begin
                timed_out = 1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic solve_and_compare(input string tag, input logic [NCELLS-1:0] m);
        bit found;
        int len;
        int cyc;
        bit to;
        logic [NMOVES-1:0][3:0] p;
        ref_solve(m, found, len, p);
        pulse_start(m);
        wait_flag(cyc, to);
        check({tag, "_timeout"}, 400'(to), 400'(0));
        check({tag, "_ready"}, 400'(bus.path_ready), 400'(found));
        check({tag, "_nopath"}, 400'(bus.no_path), 400'(!found));
        check({tag, "_len"}, 400'(bus.path_length), 400'(len));
        check({tag, "_path"}, 400'(bus.path), 400'(p));
    endtask

    initial begin
        int cyc;
        int pos;
        bit to;
        bit bad;
        bus.start = 1'b0;
        bus.maze  = '0;
        rst       = 1'b0;

        // Reference maze: the only shortest route is UP5 RIGHT6 UP4 RIGHT3
        maze1 = '0;
        set_row(maze1, 0, ".#...#...G");
        set_row(maze1, 1, ".#.#.#.#..");
        set_row(maze1, 2, "...#...#..");
        set_row(maze1, 3, "##.###.#..");
        set_row(maze1, 4, ".......#..");
        set_row(maze1, 5, ".###.###..");
        set_row(maze1, 6, "...#......");
        set_row(maze1, 7, ".#.###.##.");
        set_row(maze1, 8, ".#........");
        set_row(maze1, 9, "S####.###.");
        exp1 = '0;
        for (int i = 0; i < 18; i++) begin
            if (i < 5 || (i >= 11 && i < 15)) exp1[i] = 4'b0001;
            else exp1[i] = 4'b1000;
        end
        maze3 = '0;
        for (int c = 0; c < 10; c++) maze3[50+c] = 1'b1;

        // Reset state
        #12;
        check("rst_ready", 400'(bus.path_ready), 400'(0));
        check("rst_nopath", 400'(bus.no_path), 400'(0));
        check("rst_len", 400'(bus.path_length), 400'(0));
        check("rst_path", 400'(bus.path), 400'(0));
        @(negedge clk);
        rst = 1'b1;

        // 1: reference maze
        pulse_start(maze1);
        wait_flag(cyc, to);
        check("t1_timeout", 400'(to), 400'(0));
        check("t1_ready", 400'(bus.path_ready), 400'(1));
        check("t1_nopath", 400'(bus.no_path), 400'(0));
        check("t1_len", 400'(bus.path_length), 400'(18));
        check("t1_path", 400'(bus.path), 400'(exp1));

        // 2: open grid
        solve_and_compare("t2", '0);
        pos = 90;
        bad = 0;
        for (int i = 0; i < int'(bus.path_length); i++) begin
            if (bus.path[i] == 4'b0001) pos -= 10;
            else if (bus.path[i] == 4'b1000) pos += 1;
            else bad = 1;
        end
        check("t2_len18", 400'(bus.path_length), 400'(18));
        check("t2_dirs", 400'(bad), 400'(0));
        check("t2_replay", 400'(pos), 400'(9));

        // 3: row 5 walled off
        solve_and_compare("t3", maze3);

        // 4: start cell walled
        mz     = '0;
        mz[90] = 1'b1;
        pulse_start(mz);
        wait_flag(cyc, to);
        check("t4_nopath", 400'(bus.no_path), 400'(1));
        check("t4_latency", 400'(cyc <= 3), 400'(1));

        // 5: reset in the middle of the flood, then a clean re-run
        pulse_start(maze1);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_rst_ready", 400'(bus.path_ready), 400'(0));
        check("t5_rst_nopath", 400'(bus.no_path), 400'(0));
        check("t5_rst_len", 400'(bus.path_length), 400'(0));
        check("t5_rst_path", 400'(bus.path), 400'(0));
        @(negedge clk);
        rst = 1'b1;
        pulse_start(maze1);
        wait_flag(cyc, to);
        check("t5_ready", 400'(bus.path_ready), 400'(1));
        check("t5_len", 400'(bus.path_length), 400'(18));
        check("t5_path", 400'(bus.path), 400'(exp1));

        // 6: new solve after DONE clears the old result at once
        pulse_start(maze3);
        check("t6_ready_drop", 400'(bus.path_ready), 400'(0));
        check("t6_len_clr", 400'(bus.path_length), 400'(0));
        check("t6_path_clr", 400'(bus.path), 400'(0));
        wait_flag(cyc, to);
        check("t6_nopath", 400'(bus.no_path), 400'(1));
        check("t6_ready", 400'(bus.path_ready), 400'(0));
        check("t6_path", 400'(bus.path), 400'(0));

        // Random mazes; start and goal are left free on most runs
        for (int t = 0; t < 12; t++) begin
            mz = '0;
            for (int i = 0; i < 100; i++) mz[i] = ($urandom_range(99) < 28);
            if (t % 4 != 3) begin
                mz[90] = 1'b0;
                mz[9]  = 1'b0;
            end
            solve_and_compare($sformatf("rnd%0d", t), mz);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
